regfile_multiport: RTL and testbench

//   Parametrised CPU register file: one synchronous write port, N_RD asynchronous read ports.

---
 rtl/regfile_multiport_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 30 +++
 rtl/regfile_multiport.sv | 106 ++++++++++
 tb/tb_regfile_multiport.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared defaults and clear-sequencer state encoding for the multiport register file.
package regfile_multiport_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: lock sets, write clears, lock wins on a same-cycle collision.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (we) pending_nxt[waddr] = 1'b0;
    if (lock_en) pending_nxt[lock_addr] = 1'b1;
    if (ZERO_REG != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file: one synchronous write port, N_RD combinational read ports,
// optional write bypass / hardwired r0, pending scoreboard and hardware clear sequencer.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  output logic [N_RD-1:0]          rd_pending,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              idle;
  logic              wr_drop;
  logic              wr_fire;

  assign idle    = (state == ST_IDLE);
  assign wr_drop = (ZERO_REG != 0) && (waddr == '0);
  assign wr_fire = idle && we && !wr_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Clear walks every entry once, then returns to IDLE with the pointer wrapped.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: begin
        if (clear_req) state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == ST_CLEAR) busy = 1'b1;
  end

  // Array has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) mem[clr_ptr] <= '0;
      else if (wr_fire)      mem[waddr]   <= wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .lock_en   (lock_en && idle),
    .lock_addr (lock_addr),
    .we        (we && idle),
    .waddr     (waddr),
    .pending   (pending)
  );

  for (genvar i = 0; i < int'(N_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    logic              byp_hit;

    assign ra       = raddr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS != 0) && wr_fire && (waddr == ra);

    assign rdata[i*DATA_W +: DATA_W] = busy     ? '0    :
                                       zero_hit ? '0    :
                                       byp_hit  ? wdata : mem[ra];
    assign rd_pending[i] = !busy && pending[ra] && !byp_hit;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (ZERO_REG=1, BYPASS=1, two read ports).
module tb_regfile_multiport;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned N_RD   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic [N_RD*ADDR_W-1:0] raddr;
  logic [N_RD*DATA_W-1:0] rdata;
  logic                   lock_en;
  logic [ADDR_W-1:0]      lock_addr;
  logic [N_RD-1:0]        rd_pending;
  logic                   clear_req;
  logic                   busy;

  int passed = 0;
  int total  = 0;

  regfile_multiport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .lock_en    (lock_en),
    .lock_addr  (lock_addr),
    .rd_pending (rd_pending),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_rd(input int p0, input int p1);
    raddr = {ADDR_W'(p1), ADDR_W'(p0)};
  endtask

  // Counts cycles with busy high, bounded so a stuck sequencer still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    lock_en = 1'b0; lock_addr = '0; clear_req = 1'b0;

    // 1. reset clear
    step();
    rst = 1'b0;
    settle();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_pending", 32'(rd_pending), 32'd0);
    count_busy(n);
    chk("reset_busy_cycles", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      set_rd(a, 15 - a);
      settle();
      chk($sformatf("cleared_r%0d", a), 32'(rdata), 32'h0000_0000);
    end

    // 2. write then read; same-cycle bypass
    we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; set_rd(3, 3);
    step();
    we = 1'b0; set_rd(5, 5);
    settle();
    chk("read_r5_both", 32'(rdata), 32'hBEEF_BEEF);
    we = 1'b1; waddr = 4'd3; wdata = 16'h1234; set_rd(3, 5);
    settle();
    chk("bypass_r3", 32'(rdata), 32'hBEEF_1234);
    step();
    we = 1'b0; set_rd(3, 3);
    settle();
    chk("stored_r3", 32'(rdata), 32'h1234_1234);

    // 3. hardwired zero register
    we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; lock_en = 1'b1; lock_addr = 4'd0; set_rd(0, 0);
    settle();
    chk("r0_no_bypass", 32'(rdata), 32'd0);
    chk("r0_no_pending_now", 32'(rd_pending), 32'd0);
    step();
    we = 1'b0; lock_en = 1'b0;
    settle();
    chk("r0_reads_zero", 32'(rdata), 32'd0);
    chk("r0_never_pending", 32'(rd_pending), 32'd0);

    // 4. scoreboard
    lock_en = 1'b1; lock_addr = 4'd7;
    step();
    lock_en = 1'b0; set_rd(5, 7);
    settle();
    chk("lock_r7_pending", 32'(rd_pending), 32'b10);
    we = 1'b1; waddr = 4'd7; wdata = 16'h7777;
    settle();
    chk("r7_bypass_unpends", 32'(rd_pending), 32'b00);
    chk("r7_bypass_data", 32'(rdata), 32'h7777_BEEF);
    step();
    we = 1'b0;
    settle();
    chk("r7_pending_cleared", 32'(rd_pending), 32'b00);
    chk("r7_stored", 32'(rdata), 32'h7777_BEEF);
    lock_en = 1'b1; lock_addr = 4'd9; we = 1'b1; waddr = 4'd9; wdata = 16'h9999; set_rd(9, 9);
    step();
    lock_en = 1'b0; we = 1'b0;
    settle();
    chk("r9_lock_wins", 32'(rd_pending), 32'b11);
    chk("r9_data", 32'(rdata), 32'h9999_9999);

    // 5. requested clear, write during busy ignored
    we = 1'b1; waddr = 4'd2; wdata = 16'hAAAA;
    step();
    we = 1'b0; set_rd(2, 9);
    settle();
    chk("r2_before_clear", 32'(rdata), 32'h9999_AAAA);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    settle();
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_rdata_forced", 32'(rdata), 32'd0);
    chk("clear_pending_forced", 32'(rd_pending), 32'd0);
    we = 1'b1; waddr = 4'd4; wdata = 16'h4444;
    count_busy(n);
    we = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd16);
    set_rd(2, 4);
    settle();
    chk("r2_r4_zero", 32'(rdata), 32'd0);
    set_rd(2, 9);
    settle();
    chk("r9_pending_survives", 32'(rd_pending), 32'b10);

    // 6. reset at clear cycle 8
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 7; c++) step();
    chk("midclear_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    chk("restart_busy_cycles", 32'(n), 32'd16);
    set_rd(9, 9);
    settle();
    chk("pending_reset", 32'(rd_pending), 32'b00);
    chk("r9_zero_after_restart", 32'(rdata), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
